uart_switch_nport: RTL
======================

// Module: uart_switch_nport
// PURPOSE
//  Parametrised UART packet switch: one serial input, N_PORTS serial outputs.
//  Programming mode (prog=1): (addr,port) byte pairs fill an address table.
//  Data mode (prog=0): (target,data) pairs are looked up and data is re-sent on the mapped port.
//  Adds configurable ports/table depth/bit period, parity and stop checking, and error/drop reporting.
// PARAMETERS
//  N_PORTS       4   number of serial outputs (2..16)
//  DEPTH         8   address-table entries (1..16)
//  CLKS_PER_BIT  16  clocks per UART bit (even, >=4)
// PORTS
//  clk       in   1        single clock, all logic on posedge
//  rst       in   1        asynchronous reset, active-high
//  prog      in   1        1=programming mode, 0=data mode
//  sin       in   1        serial input, idle high
//  sout      out  N_PORTS  serial outputs, idle high
//  rx_err    out  1        1-cycle pulse: parity or stop-bit error
//  cfg_err   out  1        1-cycle pulse: port>=N_PORTS, or new addr with table full
//  drop      out  1        1-cycle pulse: data pair target not in table
//  tbl_full  out  1        level: all DEPTH entries valid
// BEHAVIOUR
//  Reset: sout all 1, rx_err/cfg_err/drop 0, tbl_full 0, table valid bits cleared,
//   RX/TX FSMs IDLE, pair pointer FIRST. Reset mid-frame aborts frame; sout=1 immediately.
//  Frame (RX and TX): start 0, 8 data bits LSB first, odd parity bit (ones in data+parity odd), stop 1;
//   each bit CLKS_PER_BIT clocks.
//  sin passes a 2-flop synchroniser; all timing below is relative to the synchronised signal.
//  RX FSM: IDLE -> START on 1->0; at CLKS_PER_BIT/2 re-sample: 1 -> IDLE (glitch), 0 -> DATA.
//   DATA/PARITY/STOP sampled every CLKS_PER_BIT from start centre.
//   After stop sample: good -> byte_valid 1 cycle; bad parity or stop=0 -> rx_err, byte discarded,
//   pair pointer -> FIRST. STOP -> IDLE.
//  Pairing: mode latched from prog at FIRST byte_valid; pair completes in latched mode
//   even if prog toggles mid-pair.
//  Prog pair: port>=N_PORTS -> cfg_err, no write. Addr already valid -> overwrite port.
//   Else write lowest free entry. None free -> cfg_err, no write.
//   Table updates the cycle after 2nd byte_valid; tbl_full reflects it the same cycle.
//  Data pair: fully associative compare of target vs valid entries (at most one match by construction).
//   Hit -> TX of mapped port loads data; start bit on sout[p] 2 cycles after 2nd byte_valid.
//   Miss -> drop pulse, same cycle as TX load would occur.
//  TX: one engine per port, independent. A load always finds TX idle: a pair spans 22 bit times,
//   a TX frame 11. No queueing required.
//  Idle sout is 1. Exactly one sout moves per hit. Unmapped ports never toggle.
// TESTING
//  T1: N_PORTS=4; program FE->0, 21->3; send (FE,E2) -> sout[0] frame 0,E2 LSB-first,
//   parity 1, stop 1; sout[1..3] stay 1.
//  T2: send (21,00) -> sout[3] frame data 00, parity 1; then (33,55) unmapped -> one drop pulse,
//   all sout stay 1.
//  T3: corrupt parity on first byte of pair -> rx_err pulse, no output.
//   Next good pair (FE,0F) routes to sout[0]: pairing realigned.
//  T4: DEPTH=4; program 4 distinct addrs -> tbl_full=1. 5th new addr -> cfg_err, table unchanged.
//   Reprogram existing addr to port 2 -> no error, routes to sout[2].
//  T5: program (10,07) with N_PORTS=4 -> cfg_err. Toggle prog after first byte of a pair
//   -> pair handled in latched mode.
//  T6: assert rst mid-TX on sout[0] -> sout all 1 within reset. Table empty: (FE,E2) -> drop.
//   1-cycle low glitch on sin -> no byte.

Source files
------------

// File: rtl/uart_switch_nport.sv
// UART packet switch: one serial input, N_PORTS serial outputs routed through a
// programmable address table of (addr, port) entries.
module uart_switch_nport #(
    parameter int N_PORTS      = 4,
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog,
    input  logic               sin,
    output logic [N_PORTS-1:0] sout,
    output logic               rx_err,
    output logic               cfg_err,
    output logic               drop,
    output logic               tbl_full
);

    // state      | meaning
    // RX_IDLE    | line idle, waiting for falling edge
    // RX_START   | counting to start-bit centre, glitch rejection
    // RX_DATA    | sampling 8 data bits, LSB first
    // RX_PARITY  | sampling odd parity bit
    // RX_STOP    | sampling stop bit, then byte_valid or rx_err

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(N_PORTS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]    NP8       = 8'(N_PORTS);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    rx_state_t     rx_state;
    logic          sin_s1, sin_s2, sin_d;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          rx_par;
    logic          byte_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sin_s1     <= 1'b1;
            sin_s2     <= 1'b1;
            sin_d      <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            rx_par     <= 1'b0;
            byte_valid <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            sin_s1     <= sin;
            sin_s2     <= sin_s1;
            sin_d      <= sin_s2;
            byte_valid <= 1'b0;
            rx_err     <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (sin_d && !sin_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else if (sin_s2) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= BIT_LAST;
                        bit_idx  <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_byte <= {sin_s2, rx_byte[7:1]};
                        rx_cnt  <= BIT_LAST;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_par   <= sin_s2;
                        rx_cnt   <= BIT_LAST;
                        rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        if (sin_s2 && (^{rx_byte, rx_par})) byte_valid <= 1'b1;
                        else                                rx_err     <= 1'b1;
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    logic [DEPTH-1:0]  tbl_valid;
    logic [7:0]        tbl_addr [DEPTH];
    logic [PW-1:0]     tbl_port [DEPTH];
    logic              pair_second;
    logic              pair_mode;
    logic [7:0]        byte0;
    logic              hit, free;
    logic [IW-1:0]     hit_idx, free_idx;
    logic [N_PORTS-1:0] tx_load;
    logic [7:0]        tx_data;

    // Both pair kinds key on the first byte, so one lookup serves programming and routing.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl_valid[i] && tbl_addr[i] == byte0) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!tbl_valid[i]) begin
                free     = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign tbl_full = &tbl_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_valid   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_addr[i] <= '0;
                tbl_port[i] <= '0;
            end
            pair_second <= 1'b0;
            pair_mode   <= 1'b0;
            byte0       <= '0;
            cfg_err     <= 1'b0;
            drop        <= 1'b0;
            tx_load     <= '0;
            tx_data     <= '0;
        end else begin
            cfg_err <= 1'b0;
            drop    <= 1'b0;
            tx_load <= '0;
            if (rx_err) begin
                pair_second <= 1'b0;
            end else if (byte_valid) begin
                if (!pair_second) begin
                    pair_second <= 1'b1;
                    pair_mode   <= prog;
                    byte0       <= rx_byte;
                end else begin
                    pair_second <= 1'b0;
                    if (pair_mode) begin
                        if (rx_byte >= NP8) begin
                            cfg_err <= 1'b1;
                        end else if (hit) begin
                            tbl_port[hit_idx] <= rx_byte[PW-1:0];
                        end else if (free) begin
                            tbl_valid[free_idx] <= 1'b1;
                            tbl_addr[free_idx]  <= byte0;
                            tbl_port[free_idx]  <= rx_byte[PW-1:0];
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end else if (hit) begin
                        tx_load[tbl_port[hit_idx]] <= 1'b1;
                        tx_data                    <= rx_byte;
                    end else begin
                        drop <= 1'b1;
                    end
                end
            end
        end
    end

    // One transmitter per port; a pair takes twice as long as a frame, so a load never finds it busy.
    for (genvar p = 0; p < N_PORTS; p++) begin : g_tx
        logic          busy;
        logic          line;
        logic [9:0]    shift;
        logic [3:0]    left;
        logic [CW-1:0] cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                busy  <= 1'b0;
                line  <= 1'b1;
                shift <= '1;
                left  <= '0;
                cnt   <= '0;
            end else if (!busy) begin
                if (tx_load[p]) begin
                    busy  <= 1'b1;
                    line  <= 1'b0;
                    shift <= {1'b1, ~^tx_data, tx_data};
                    left  <= 4'd10;
                    cnt   <= BIT_LAST;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (left == 4'd0) begin
                busy <= 1'b0;
            end else begin
                line  <= shift[0];
                shift <= {1'b1, shift[9:1]};
                left  <= left - 1'b1;
                cnt   <= BIT_LAST;
            end
        end

        assign sout[p] = line;
    end

endmodule
